car_datapath: RTL

Datapath partner of the per-car control FSM in the tower-defence stage. It consumes the FSM's one-hot state strobes (`wait_start`, `delay`, `erase_car`, `increment`, `draw_car`, `destroyed_state`) and returns the feedback it waits on: `initial_delay_done`, `erase_done` and `draw_done`. It owns the car's position along a fixed two-leg path and generates the per-pixel VGA writes (160x120, 3-bit colour) for erasing and redrawing the square car sprite.

---
 rtl/car_datapath.sv | 122 ++++++++++++
 1 files changed

// File: rtl/car_datapath.sv
// Car datapath for the tower-defence stage: path position, delay timer and
// per-pixel erase/draw writes for the car sprite on a 160x120 VGA frame.
module car_datapath #(
  parameter int unsigned CAR_SIZE     = 4,
  parameter logic [31:0] DELAY_CYCLES = 32'd50_000_000,
  parameter logic [7:0]  START_X      = 8'd0,
  parameter logic [6:0]  START_Y      = 7'd56,
  parameter logic [7:0]  TURN_X       = 8'd120,
  parameter logic [6:0]  END_Y        = 7'd110,
  parameter logic [2:0]  CAR_COLOUR   = 3'b100,
  parameter logic [2:0]  BG_COLOUR    = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wait_start,
  input  logic       delay,
  input  logic       erase_car,
  input  logic       increment,
  input  logic       draw_car,
  input  logic       destroyed_state,
  output logic       initial_delay_done,
  output logic       erase_done,
  output logic       draw_done,
  output logic [7:0] x_pos,
  output logic [6:0] y_pos,
  output logic       reached_end,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot
);

  localparam int unsigned HW = $clog2(CAR_SIZE);
  localparam int unsigned PW = 2 * HW;
  localparam logic [PW-1:0] PC_LAST = '1;

  logic [7:0]    x_reg, x_next;
  logic [6:0]    y_reg, y_next;
  logic          dir_reg, dir_next;
  logic          end_reg, end_next;
  logic [31:0]   cnt_reg, cnt_next;
  logic [PW-1:0] pc_reg, pc_next;

  logic [HW-1:0] col, row;
  logic [8:0]    px;
  logic [7:0]    py;
  logic          pixel_last;
  logic          sprite_active;

  // Path motion: +x until TURN_X, then +y until END_Y. A car already sitting
  // on TURN_X with dir clear turns on its first increment without an x step.
  always_comb begin
    x_next   = x_reg;
    y_next   = y_reg;
    dir_next = dir_reg;
    end_next = end_reg;
    if (wait_start) begin
      x_next   = START_X;
      y_next   = START_Y;
      dir_next = 1'b0;
      end_next = 1'b0;
    end else if (increment && !destroyed_state && !end_reg) begin
      if (!dir_reg && x_reg != TURN_X) begin
        x_next = x_reg + 8'd1;
        if (x_reg + 8'd1 == TURN_X) begin
          dir_next = 1'b1;
        end
      end else begin
        dir_next = 1'b1;
        y_next   = y_reg + 7'd1;
        if (y_reg + 7'd1 == END_Y) begin
          end_next = 1'b1;
        end
      end
    end
  end

  always_comb begin
    cnt_next = delay ? cnt_reg + 32'd1 : 32'd0;
    pc_next  = (draw_car || erase_car) ? pc_reg + {{(PW-1){1'b0}}, 1'b1} : '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_reg   <= START_X;
      y_reg   <= START_Y;
      dir_reg <= 1'b0;
      end_reg <= 1'b0;
      cnt_reg <= 32'd0;
      pc_reg  <= '0;
    end else begin
      x_reg   <= x_next;
      y_reg   <= y_next;
      dir_reg <= dir_next;
      end_reg <= end_next;
      cnt_reg <= cnt_next;
      pc_reg  <= pc_next;
    end
  end

  // Low half of the pixel counter walks columns, high half walks rows.
  assign col        = pc_reg[HW-1:0];
  assign row        = pc_reg[PW-1:HW];
  assign px         = {1'b0, x_reg} + 9'(col);
  assign py         = {1'b0, y_reg} + 8'(row);
  assign pixel_last = (pc_reg == PC_LAST);

  assign sprite_active = resetn && (draw_car || erase_car) && !destroyed_state;

  assign x_pos       = x_reg;
  assign y_pos       = y_reg;
  assign reached_end = end_reg;
  assign vga_x       = px[7:0];
  assign vga_y       = py[6:0];
  assign vga_colour  = draw_car ? CAR_COLOUR : BG_COLOUR;
  assign plot        = sprite_active && (px < 9'd160) && (py < 8'd120);

  assign draw_done          = resetn && draw_car && pixel_last;
  assign erase_done         = resetn && erase_car && !draw_car && pixel_last;
  assign initial_delay_done = resetn && delay && (cnt_reg == DELAY_CYCLES - 32'd1);

endmodule
